// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
//
// Purpose:
//   Takes the debounced, clk-synchronous button level and classifies each
//   press as short, long or double. Every event is a registered one-cycle
//   pulse so downstream control logic can treat it as a single-shot command.
//   A level `held` flag and a wrapping 8-bit press counter are also provided.
//
// Parameters:
//   LONG_CYCLES - consecutive high samples after which a first press is long
//   GAP_CYCLES  - maximum low samples between press 1 and press 2 for a double
//   CNT_W       - width of the internal cycle counter
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   btn_in        in   debounced button level (1 = pressed), synchronous to clk
//   press_pulse   out  one cycle on every accepted rising edge
//   release_pulse out  one cycle on the falling edge of an accepted press
//   short_press   out  one cycle when a single short press is confirmed
//   long_press    out  one cycle when a first press reaches LONG_CYCLES
//   double_press  out  one cycle on the release of a second press
//   held          out  level, high while the long press is still held
//   press_count   out  number of press_pulse events, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event_classifier #(
  parameter int LONG_CYCLES = 100,
  parameter int GAP_CYCLES  = 50,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_SECOND    = 3'd4
  } state_t;

  // A press turns long on the sample where cnt already holds LONG_CYCLES-1,
  // i.e. on the LONG_CYCLES-th high sample (the rising sample loads cnt=1).
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  // The gap times out on the sample after cnt has reached GAP_CYCLES, which
  // lets a rise arriving in that very cycle still count as a second press.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Saturating increment: the cycle counter must never wrap back to a small
  // value that could be mistaken for a fresh timing window.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             double_press_q, double_press_d;
  logic             held_q, held_d;
  logic [7:0]       press_count_q, press_count_d;

  logic             rise_s;
  logic             fall_s;

  // Edges against the previous sample; btn_q resets high so a button held
  // through reset release does not look like a fresh press.
  always_comb begin
    rise_s = btn_in & ~btn_q;
    fall_s = ~btn_in & btn_q;
  end

  // Next-state, counter and event decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    btn_d           = btn_in;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;
    double_press_d  = 1'b0;
    held_d          = held_q;
    press_count_d   = press_count_q;

    case (state_q)
      ST_IDLE: begin
        held_d = 1'b0;
        if (rise_s) begin
          state_d       = ST_PRESSED;
          cnt_d         = CNT_ONE;
          press_pulse_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_PRESSED: begin
        if (fall_s) begin
          state_d         = ST_WAIT_GAP;
          cnt_d           = CNT_ONE;
          release_pulse_d = 1'b1;
        end else if (btn_in && (cnt_q == LONG_LAST)) begin
          state_d      = ST_LONG_HELD;
          cnt_d        = CNT_ZERO;
          long_press_d = 1'b1;
          held_d       = 1'b1;
        end else if (btn_in) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_LONG_HELD: begin
        if (fall_s) begin
          state_d         = ST_IDLE;
          cnt_d           = CNT_ZERO;
          held_d          = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          held_d = 1'b1;
        end
      end

      ST_WAIT_GAP: begin
        // Rise is tested first so it wins over a timeout in the same cycle.
        if (rise_s) begin
          state_d       = ST_SECOND;
          cnt_d         = sat_inc(cnt_q);
          press_pulse_d = 1'b1;
        end else if (!btn_in && (cnt_q >= GAP_LAST)) begin
          state_d       = ST_IDLE;
          cnt_d         = CNT_ZERO;
          short_press_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_SECOND: begin
        if (fall_s) begin
          state_d         = ST_IDLE;
          cnt_d           = CNT_ZERO;
          double_press_d  = 1'b1;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      default: begin
        // Unreachable encodings fall back to a quiet idle.
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        held_d  = 1'b0;
      end
    endcase

    // The counter moves in the same cycle its press_pulse is raised.
    if (press_pulse_d) begin
      press_count_d = press_count_q + 8'd1;
    end else begin
      press_count_d = press_count_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= CNT_ZERO;
      btn_q           <= 1'b1;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      double_press_q  <= 1'b0;
      held_q          <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_q           <= btn_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
      double_press_q  <= double_press_d;
      held_q          <= held_d;
      press_count_q   <= press_count_d;
    end
  end

  // Drive ports straight from the flops.
  always_comb begin
    press_pulse   = press_pulse_q;
    release_pulse = release_pulse_q;
    short_press   = short_press_q;
    long_press    = long_press_q;
    double_press  = double_press_q;
    held          = held_q;
    press_count   = press_count_q;
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_event_classifier
//
// Self-checking bench for button_event_classifier with default parameters.
// A reference model tracks run lengths of the sampled button level and
// predicts every output each cycle; a table of press patterns checks pulse
// totals, and hand-written sequences cover reset and counter-wrap corners.
// -----------------------------------------------------------------------------
module tb_button_event_classifier;

  localparam int LONG = 100;
  localparam int GAP  = 50;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [7:0] press_count;

  button_event_classifier #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // m_active: 0 no press in progress, 1 first press, 2 second press
  logic m_prev;
  int   m_active;
  bit   m_long;
  bit   m_gap;
  int   m_run;
  int   m_low;
  int   m_count;
  logic e_press, e_rel, e_short, e_long, e_dbl, e_held;

  // observed pulse totals
  int n_press, n_rel, n_short, n_long, n_dbl;

  function void model_reset();
    m_prev   = 1'b1;
    m_active = 0;
    m_long   = 1'b0;
    m_gap    = 1'b0;
    m_run    = 0;
    m_low    = 0;
    m_count  = 0;
    e_press  = 1'b0;
    e_rel    = 1'b0;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_dbl    = 1'b0;
    e_held   = 1'b0;
  endfunction

  function void model_step(input logic b);
    logic r;
    logic f;
    r = b & ~m_prev;
    f = ~b & m_prev;
    m_prev  = b;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    if (r) begin
      if (m_gap) begin
        m_gap    = 1'b0;
        m_active = 2;
        e_press  = 1'b1;
        m_count  = (m_count + 1) % 256;
      end else if (m_active == 0) begin
        m_active = 1;
        m_run    = 1;
        m_long   = 1'b0;
        e_press  = 1'b1;
        m_count  = (m_count + 1) % 256;
      end
    end else if (f) begin
      if (m_active != 0) begin
        e_rel = 1'b1;
        if (m_active == 2) begin
          e_dbl = 1'b1;
        end else if (!m_long) begin
          m_gap = 1'b1;
          m_low = 1;
        end
        m_active = 0;
        m_long   = 1'b0;
      end
    end else if (b) begin
      if (m_active == 1 && !m_long) begin
        m_run = m_run + 1;
        if (m_run == LONG) begin
          m_long = 1'b1;
          e_long = 1'b1;
        end
      end
    end else begin
      if (m_gap) begin
        m_low = m_low + 1;
        if (m_low == GAP + 1) begin
          e_short = 1'b1;
          m_gap   = 1'b0;
        end
      end
    end
    e_held = m_long;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive btn, let the edge happen, then compare everything.
  task automatic cycle(input logic b);
    btn_in = b;
    @(posedge clk);
    model_step(b);
    #1;
    check_vec("per_cycle {press,rel,short,long,dbl,held,count}",
              {1'b0, press_pulse, release_pulse, short_press, long_press,
               double_press, held, press_count},
              {1'b0, e_press, e_rel, e_short, e_long, e_dbl, e_held, 8'(m_count)});
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_short += int'(short_press);
    n_long  += int'(long_press);
    n_dbl   += int'(double_press);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) cycle(b);
  endtask

  task automatic clear_totals();
    n_press = 0;
    n_rel   = 0;
    n_short = 0;
    n_long  = 0;
    n_dbl   = 0;
  endtask

  // Assert reset asynchronously away from the edge, confirm quiet outputs.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    model_reset();
    check_vec("reset_outputs",
              {1'b0, press_pulse, release_pulse, short_press, long_press,
               double_press, held, press_count}, 15'd0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string name;
    int    hi1;
    int    lo1;
    int    hi2;
    int    x_press;
    int    x_rel;
    int    x_short;
    int    x_long;
    int    x_dbl;
  } vec_t;

  vec_t tbl[8];

  int rel_at;
  int short_at;

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    model_reset();
    clear_totals();

    tbl[0] = '{"short",        30,  0,   0, 1, 1, 1, 0, 0};
    tbl[1] = '{"long",        150,  0,   0, 1, 1, 0, 1, 0};
    tbl[2] = '{"double",       20, 20,  20, 2, 2, 0, 0, 1};
    tbl[3] = '{"gap49",        20, 49,  20, 2, 2, 0, 0, 1};
    tbl[4] = '{"gap50_edge",   20, 50,  20, 2, 2, 0, 0, 1};
    tbl[5] = '{"gap51",        20, 51,  20, 2, 2, 2, 0, 0};
    tbl[6] = '{"second_long",  10, 10, 200, 2, 2, 0, 0, 1};
    tbl[7] = '{"long_then_new",120, 5,  10, 2, 2, 1, 1, 0};

    @(posedge clk);
    #1;
    do_reset(10);

    for (int k = 0; k < 8; k++) begin
      btn_in = 1'b0;
      do_reset(2);
      clear_totals();
      run(1'b0, 5);
      run(1'b1, tbl[k].hi1);
      if (tbl[k].lo1 > 0) run(1'b0, tbl[k].lo1);
      if (tbl[k].hi2 > 0) run(1'b1, tbl[k].hi2);
      run(1'b0, 80);
      check_int({tbl[k].name, ".press"},  n_press, tbl[k].x_press);
      check_int({tbl[k].name, ".release"}, n_rel,  tbl[k].x_rel);
      check_int({tbl[k].name, ".short"},  n_short, tbl[k].x_short);
      check_int({tbl[k].name, ".long"},   n_long,  tbl[k].x_long);
      check_int({tbl[k].name, ".double"}, n_dbl,   tbl[k].x_dbl);
      check_int({tbl[k].name, ".count"},  int'(press_count), tbl[k].x_press);
    end

    // Short-press timing: release on the first low sample, short 50 later.
    btn_in = 1'b0;
    do_reset(2);
    run(1'b0, 5);
    run(1'b1, 30);
    rel_at   = -1;
    short_at = -1;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0);
      if (release_pulse && rel_at < 0) rel_at = i;
      if (short_press && short_at < 0) short_at = i;
    end
    check_int("short_timing.release_cycle", rel_at, 0);
    check_int("short_timing.short_cycle", short_at, 50);

    // Button held across reset release is ignored until low then high.
    btn_in = 1'b1;
    do_reset(10);
    clear_totals();
    run(1'b1, 20);
    check_int("held_through_reset.press", n_press, 0);
    cycle(1'b0);
    cycle(1'b1);
    check_int("held_through_reset.new_press", int'(press_pulse), 1);
    check_int("held_through_reset.count", int'(press_count), 1);

    // Reset during the gap wait drops the pending short press.
    btn_in = 1'b0;
    do_reset(2);
    run(1'b0, 3);
    run(1'b1, 20);
    run(1'b0, 10);
    do_reset(3);
    clear_totals();
    run(1'b0, 100);
    check_int("reset_in_gap.short", n_short, 0);
    check_int("reset_in_gap.count", int'(press_count), 0);

    // Counter wrap after 256 short presses.
    btn_in = 1'b0;
    do_reset(2);
    run(1'b0, 3);
    for (int p = 0; p < 256; p++) begin
      run(1'b1, 3);
      run(1'b0, 53);
    end
    check_int("wrap.count_256", int'(press_count), 0);
    run(1'b1, 3);
    check_int("wrap.count_257", int'(press_count), 1);
    run(1'b0, 60);

    // Randomized runs, model checked every cycle.
    btn_in = 1'b0;
    do_reset(2);
    for (int s = 0; s < 80; s++) begin
      int len;
      int bucket;
      bucket = int'($urandom_range(0, 3));
      case (bucket)
        0:       len = int'($urandom_range(1, 5));
        1:       len = int'($urandom_range(GAP - 3, GAP + 3));
        2:       len = int'($urandom_range(LONG - 3, LONG + 3));
        default: len = int'($urandom_range(1, 150));
      endcase
      run(s[0], len);
      if ($urandom_range(0, 19) == 0) do_reset(2);
    end
    run(1'b0, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Sits directly downstream of the debouncer and consumes its clean, clk-synchronous button level.
- Classifies each press as short, long or double, and emits one-cycle event pulses that the control logic can use as single-shot commands.
- Also provides a level `held` flag and a wrapping press counter for display and debug.

Parameters:
- LONG_CYCLES, 100, consecutive high cycles after which a press counts as long (>=2).
- GAP_CYCLES, 50, maximum low cycles between releasing press 1 and starting press 2 for a double (>=2).
- CNT_W, 16, width of the internal cycle counter; LONG_CYCLES and GAP_CYCLES must be < 2**CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btn_in  input  1  debounced button level from the debouncer (1 = pressed), already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on every accepted rising edge.
- release_pulse  output  1  one-cycle pulse on every falling edge of an accepted press.
- short_press  output  1  one-cycle pulse for a single short press.
- long_press  output  1  one-cycle pulse when a first press reaches LONG_CYCLES.
- double_press  output  1  one-cycle pulse on the release of a second press.
- held  output  1  level; high while in LONG_HELD.
- press_count  output  8  count of press_pulse events, wraps 255 -> 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, cnt = 0, all pulse outputs 0, held = 0, press_count = 0.
  - btn_q (registered copy of btn_in) resets to 1, so a button held through reset release is ignored until it is released.
- Edge detection:
  - rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
  - btn_q <= btn_in every cycle.
- All outputs are registered. An event sampled at clock edge N is visible for exactly one cycle, between edges N and N+1. Pulses are never stretched.
- IDLE:
  - On rise: go to PRESSED, cnt <= 1, press_pulse.
- PRESSED (first press):
  - Each cycle with btn_in = 1: cnt++.
  - When btn_in = 1 and cnt == LONG_CYCLES-1: go to LONG_HELD, long_press pulse, held <= 1.
  - On fall: go to WAIT_GAP, cnt <= 1, release_pulse.
- LONG_HELD:
  - held = 1. On fall: go to IDLE, held <= 0, release_pulse.
  - Never emits short_press or double_press.
- WAIT_GAP:
  - Each low cycle: cnt++.
  - On rise while cnt < GAP_CYCLES: go to SECOND, press_pulse.
  - When cnt == GAP_CYCLES with btn_in still 0: short_press pulse, go to IDLE.
  - Boundary: a rise sampled in the same cycle that cnt reaches GAP_CYCLES counts as a second press. Rise takes priority over timeout.
- SECOND:
  - Waits for release, with no long detection.
  - On fall: double_press pulse plus release_pulse, go to IDLE.
  - cnt saturates at 2**CNT_W-1 and never wraps.
- press_count increments in the same cycle that press_pulse is set, and wraps modulo 256.
- At most one of short_press, long_press and double_press is high in any cycle.
- Reset asserted mid-operation aborts the sequence. No pending short_press or double_press is emitted after reset release.
- Because btn_q resets to 1, the first press after reset requires btn_in to go low and then high.

Test Plan:
- Short press, with LONG=100 and GAP=50: rst low 10 cycles, btn 1 for 30 cycles, then 0.
  -> press_pulse once; release_pulse 1 cycle after the fall; short_press exactly 50 cycles after the fall; press_count = 1; no long or double.
- Long press: btn 1 for 150 cycles.
  -> long_press at the 100th high cycle; held high from then until 1 cycle after the release; release_pulse on release; no short_press; press_count = 1.
- Double press: 20 cycles high, 20 low, 20 high, then low.
  -> two press_pulses; double_press and release_pulse together 1 cycle after the second fall; no short_press; press_count = 2.
- Gap boundary: first release followed by 49 low cycles, then high -> double_press.
  - Repeated with 51 low cycles -> short_press at low cycle 50; the later rise starts a new PRESSED sequence.
- Reset interactions:
  - btn held 1 across reset release -> no press_pulse until btn goes 0 then 1.
  - rst pulsed low during WAIT_GAP -> all outputs 0, no short_press afterwards.
- Counter wrap: 256 short presses -> press_count returns to 0 and the 257th press gives 1.
